// File: rtl/ring_router_arbiter_pkg.sv
// Shared types and helpers for the debug ring router output arbiter.
package ring_router_arbiter_pkg;

   // Debug interconnect flit: valid/last framing around a 16-bit payload.
   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;

   // grant_id value that selects the through-ring input.
   localparam int RING_SRC_ID = 0;

   // Width of grant_id: the ring plus num_local local ports.
   function automatic int grant_id_width(input int num_local);
      return (num_local < 1) ? 1 : $clog2(num_local + 1);
   endfunction

endpackage

// File: rtl/ring_router_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at
// or after ptr, searching cyclically.
module ring_router_arbiter_rr_arbiter #(
   parameter int N  = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   int  idx;
   logic found;

   // Walk the request vector starting at ptr; the first hit wins.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && (((req >> idx) & N'(1)) != '0)) begin
            gnt   = N'(1) << idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ring_router_arbiter.sv
// Worm-aware arbiter sharing one ring output link between the through-ring
// input and NUM_LOCAL local injection ports. A grant is held from the head
// flit through the flit with last set.
//
// Handshake: a flit moves on a source when its valid and ready are high in
// the same cycle; ready of the selected source is out_mux_ready, combinational.
module ring_router_arbiter
   import ring_router_arbiter_pkg::*;
#(
   parameter int NUM_LOCAL   = 2,
   parameter int RING_WEIGHT = 4,
   localparam int GW = grant_id_width(NUM_LOCAL)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  dii_flit              in_ring,
   output logic                 in_ring_ready,
   input  dii_flit              in_local [NUM_LOCAL],
   output logic [NUM_LOCAL-1:0] in_local_ready,
   output dii_flit              out_mux,
   input  logic                 out_mux_ready,
   output logic [GW-1:0]        grant_id,
   output logic                 worm_active
);

   localparam int CW = (RING_WEIGHT < 1) ? 1 : $clog2(RING_WEIGHT + 1);
   localparam int PW = (NUM_LOCAL > 1) ? $clog2(NUM_LOCAL) : 1;
   localparam logic [CW-1:0] RW = CW'(RING_WEIGHT);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WORM = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [GW-1:0]        grant_q, grant_d;
   logic [CW-1:0]        ring_cnt_q, ring_cnt_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;

   logic [NUM_LOCAL-1:0] local_req;
   logic [NUM_LOCAL-1:0] local_gnt;
   logic [GW-1:0]        local_sel;
   logic                 any_local;
   logic                 ring_wins;
   logic                 have_src;
   logic [GW-1:0]        sel;
   dii_flit              src_flit;
   logic                 xfer_last;

   ring_router_arbiter_rr_arbiter #(.N(NUM_LOCAL)) u_rr (
      .req (local_req),
      .ptr (rr_ptr_q),
      .gnt (local_gnt)
   );

   // Gather local requests and turn the one-hot local grant into a source id.
   always_comb begin
      local_sel = '0;
      for (int k = 0; k < NUM_LOCAL; k++) begin
         local_req[k] = in_local[k].valid;
         if (local_gnt[k]) local_sel = GW'(k + 1);
      end
      any_local = |local_req;
   end

   // Pick the source: locked grant in WORM, otherwise the IDLE arbitration.
   // Reset gates everything so the link goes quiet without waiting for a clock.
   always_comb begin
      ring_wins = in_ring.valid && ((ring_cnt_q < RW) || !any_local);
      sel       = '0;
      have_src  = 1'b0;
      if (state_q == S_WORM) begin
         sel      = grant_q;
         have_src = 1'b1;
      end else if (ring_wins) begin
         sel      = GW'(RING_SRC_ID);
         have_src = 1'b1;
      end else if (any_local) begin
         sel      = local_sel;
         have_src = 1'b1;
      end
      have_src = have_src && rst_n;

      src_flit = in_ring;
      for (int k = 0; k < NUM_LOCAL; k++) begin
         if (sel == GW'(k + 1)) src_flit = in_local[k];
      end
   end

   // Output mux and ready steering; only the selected source sees ready.
   always_comb begin
      out_mux       = src_flit;
      out_mux.valid = have_src && src_flit.valid;
      in_ring_ready = have_src && (sel == GW'(RING_SRC_ID)) && out_mux_ready;
      for (int k = 0; k < NUM_LOCAL; k++) begin
         in_local_ready[k] = have_src && (sel == GW'(k + 1)) && out_mux_ready;
      end
      xfer_last = out_mux.valid && out_mux_ready && src_flit.last;
   end

   // Next state, grant and fairness counters.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      ring_cnt_d = ring_cnt_q;
      rr_ptr_d   = rr_ptr_q;

      case (state_q)
         S_IDLE: begin
            if (have_src) begin
               grant_d = sel;
               if (!xfer_last) state_d = S_WORM;
            end
         end
         default: begin
            if (xfer_last) state_d = S_IDLE;
         end
      endcase

      if (xfer_last) begin
         if (sel == GW'(RING_SRC_ID)) begin
            if (ring_cnt_q != RW) ring_cnt_d = ring_cnt_q + CW'(1);
         end else begin
            ring_cnt_d = '0;
            // Source id k+1 completing means the next search starts at (k+1) mod N.
            rr_ptr_d   = PW'(int'(sel) % NUM_LOCAL);
         end
      end
      // No local contender: the ring's run of consecutive worms no longer matters.
      if ((state_q == S_IDLE) && !any_local) ring_cnt_d = '0;
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         ring_cnt_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         ring_cnt_q <= ring_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign worm_active = (state_q == S_WORM);
   assign grant_id    = grant_q;

endmodule

// File: tb/tb_ring_router_arbiter.sv
// Self-checking bench for ring_router_arbiter: directed worms plus a
// per-cycle comparison against a behavioural model of the arbitration rules.
module tb_ring_router_arbiter;
   import ring_router_arbiter_pkg::*;

   localparam int NL = 3;
   localparam int RW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   dii_flit       ring;
   dii_flit       loc [NL];
   logic          omr;
   logic          ring_rdy;
   logic [NL-1:0] loc_rdy;
   dii_flit       out;
   logic [1:0]    gid;
   logic          wa;

   int tests = 0;
   int fails = 0;

   ring_router_arbiter #(.NUM_LOCAL(NL), .RING_WEIGHT(RW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_ring        (ring),
      .in_ring_ready  (ring_rdy),
      .in_local       (loc),
      .in_local_ready (loc_rdy),
      .out_mux        (out),
      .out_mux_ready  (omr),
      .grant_id       (gid),
      .worm_active    (wa)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic dii_flit mk(input logic v, input logic l, input logic [15:0] d);
      dii_flit f;
      f.valid = v;
      f.last  = l;
      f.data  = d;
      return f;
   endfunction

   // ---------------- behavioural model ----------------
   // Model state: is a worm locked, which source, consecutive ring worm count,
   // round-robin start, and the last grant shown on grant_id.
   bit m_locked = 0;
   int m_src = 0, m_cnt = 0, m_ptr = 0, m_gid = 0;
   bit n_locked = 0;
   int n_src = 0, n_cnt = 0, n_ptr = 0, n_gid = 0;

   always @(negedge clk) begin : model_cmp
      int      src;
      int      k;
      bit      anyl;
      bit      ev;
      bit      xl;
      dii_flit f;
      logic [NL-1:0] er;
      if (!rst_n) begin
         chk("m_rst_valid", 32'(out.valid), 0);
         chk("m_rst_ring_rdy", 32'(ring_rdy), 0);
         chk("m_rst_loc_rdy", 32'(loc_rdy), 0);
         chk("m_rst_wa", 32'(wa), 0);
         chk("m_rst_gid", 32'(gid), 0);
         n_locked = 0; n_src = 0; n_cnt = 0; n_ptr = 0; n_gid = 0;
      end else begin
         anyl = 0;
         for (int i = 0; i < NL; i++) if (loc[i].valid) anyl = 1;
         if (m_locked) src = m_src;
         else if (ring.valid && (m_cnt < RW || !anyl)) src = 0;
         else begin
            src = -1;
            for (int i = 0; i < NL; i++) begin
               k = (m_ptr + i) % NL;
               if (src < 0 && loc[k].valid) src = k + 1;
            end
         end
         if (src == 0) f = ring;
         else if (src > 0) f = loc[src-1];
         else f = '0;
         ev = (src >= 0) && f.valid;
         er = '0;
         for (int i = 0; i < NL; i++) er[i] = (src == i + 1) && omr;

         chk("m_wa", 32'(wa), 32'(m_locked));
         chk("m_gid", 32'(gid), 32'(m_gid));
         chk("m_valid", 32'(out.valid), 32'(ev));
         if (ev) begin
            chk("m_data", 32'(out.data), 32'(f.data));
            chk("m_last", 32'(out.last), 32'(f.last));
         end
         chk("m_ring_rdy", 32'(ring_rdy), 32'((src == 0) && omr));
         chk("m_loc_rdy", 32'(loc_rdy), 32'(er));

         xl = ev && omr && f.last;
         n_locked = m_locked; n_src = m_src; n_cnt = m_cnt; n_ptr = m_ptr; n_gid = m_gid;
         if (!m_locked && src >= 0) begin
            n_gid = src; n_src = src; n_locked = !xl;
         end else if (m_locked && xl) begin
            n_locked = 0;
         end
         if (xl) begin
            if (src == 0) n_cnt = (m_cnt < RW) ? m_cnt + 1 : RW;
            else begin
               n_cnt = 0;
               n_ptr = src % NL;
            end
         end
         if (!m_locked && !anyl) n_cnt = 0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_locked = 0; m_src = 0; m_cnt = 0; m_ptr = 0; m_gid = 0;
      end else begin
         m_locked = n_locked; m_src = n_src; m_cnt = n_cnt; m_ptr = n_ptr; m_gid = n_gid;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      ring = '0;
      for (int i = 0; i < NL; i++) loc[i] = '0;
      omr = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   logic [15:0] seq3 [6];
   logic [15:0] seq4 [4];
   logic [1:0]  gid4 [4];

   initial begin
      clear_inputs();

      // Reset state
      do_reset();
      @(negedge clk);
      chk("reset_wa", 32'(wa), 0);
      chk("reset_gid", 32'(gid), 0);
      chk("reset_valid", 32'(out.valid), 0);
      tick();

      // Ring-only single-flit worms
      omr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ring = mk(1'b1, 1'b1, 16'h0100 + 16'(i));
         @(negedge clk);
         chk("t1_data", 32'(out.data), 32'h100 + i);
         chk("t1_ring_rdy", 32'(ring_rdy), 1);
         chk("t1_wa", 32'(wa), 0);
         tick();
      end

      // Ring worm blocks local, then local head with no bubble
      do_reset();
      loc[0] = mk(1'b1, 1'b1, 16'h0300);
      for (int i = 0; i < 3; i++) begin
         ring = mk(1'b1, i == 2, 16'h0200 + 16'(i));
         @(negedge clk);
         chk("t2_ring_data", 32'(out.data), 32'h200 + i);
         chk("t2_loc0_rdy", 32'(loc_rdy[0]), 0);
         tick();
      end
      ring = '0;
      @(negedge clk);
      chk("t2_local_valid", 32'(out.valid), 1);
      chk("t2_local_data", 32'(out.data), 32'h300);
      chk("t2_loc0_rdy_up", 32'(loc_rdy[0]), 1);
      tick();

      // Starvation bound with RING_WEIGHT=2
      do_reset();
      seq3 = '{16'h0A00, 16'h0A00, 16'h0B01, 16'h0A00, 16'h0A00, 16'h0B01};
      ring   = mk(1'b1, 1'b1, 16'h0A00);
      loc[1] = mk(1'b1, 1'b1, 16'h0B01);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t3_order", 32'(out.data), 32'(seq3[i]));
         tick();
      end

      // Local round-robin among ports 0 and 2
      do_reset();
      seq4 = '{16'h0C00, 16'h0C02, 16'h0C00, 16'h0C02};
      gid4 = '{2'd1, 2'd3, 2'd1, 2'd3};
      loc[0] = mk(1'b1, 1'b1, 16'h0C00);
      loc[2] = mk(1'b1, 1'b1, 16'h0C02);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i > 0) chk("t4_gid", 32'(gid), 32'(gid4[i-1]));
         chk("t4_data", 32'(out.data), 32'(seq4[i]));
         tick();
      end
      @(negedge clk);
      chk("t4_gid_last", 32'(gid), 32'(gid4[3]));
      tick();

      // Backpressure on a local head, ring arrives while locked
      do_reset();
      omr = 1'b0;
      loc[0] = mk(1'b1, 1'b0, 16'h0D00);
      @(negedge clk);
      chk("t5_head_valid", 32'(out.valid), 1);
      chk("t5_head_data", 32'(out.data), 32'hD00);
      tick();
      ring = mk(1'b1, 1'b1, 16'h0E55);
      @(negedge clk);
      chk("t5_wa", 32'(wa), 1);
      chk("t5_gid", 32'(gid), 1);
      chk("t5_hold_data", 32'(out.data), 32'hD00);
      chk("t5_ring_blocked", 32'(ring_rdy), 0);
      tick();
      omr = 1'b1;
      @(negedge clk);
      chk("t5_head_xfer", 32'(loc_rdy[0]), 1);
      tick();
      loc[0] = mk(1'b1, 1'b1, 16'h0D01);
      @(negedge clk);
      chk("t5_tail_data", 32'(out.data), 32'hD01);
      tick();
      loc[0] = '0;
      @(negedge clk);
      chk("t5_wa_done", 32'(wa), 0);
      chk("t5_ring_next", 32'(out.data), 32'hE55);
      tick();

      // Reset mid-worm
      do_reset();
      loc[1] = mk(1'b1, 1'b0, 16'h0E10);
      @(negedge clk);
      chk("t6_head", 32'(out.data), 32'hE10);
      tick();
      loc[1] = mk(1'b1, 1'b0, 16'h0E11);
      #1;
      chk("t6_locked", 32'(wa), 1);
      chk("t6_flit2", 32'(out.data), 32'hE11);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(out.valid), 0);
      chk("t6_rst_wa", 32'(wa), 0);
      chk("t6_rst_loc_rdy", 32'(loc_rdy), 0);
      chk("t6_rst_ring_rdy", 32'(ring_rdy), 0);
      tick();
      rst_n  = 1'b1;
      loc[1] = '0;
      ring   = mk(1'b1, 1'b0, 16'h0F00);
      @(negedge clk);
      chk("t6_new_head", 32'(out.data), 32'hF00);
      chk("t6_new_rdy", 32'(ring_rdy), 1);
      tick();
      ring = mk(1'b1, 1'b1, 16'h0F01);
      @(negedge clk);
      chk("t6_new_wa", 32'(wa), 1);
      chk("t6_new_gid", 32'(gid), 0);
      chk("t6_new_tail", 32'(out.data), 32'hF01);
      tick();
      ring = '0;
      @(negedge clk);
      chk("t6_end_wa", 32'(wa), 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ring_router_arbiter.md
# ring_router_arbiter

Worm-aware arbiter that shares one ring output link between the through-ring input and `NUM_LOCAL` local injection ports of a debug ring router. It replaces the fixed ring-priority output mux and adds two things: bounded local starvation through a ring weight counter, and round-robin fairness among the local ports. A grant is held for the whole worm, from the head flit through the flit with `last` set, so flits from different worms never interleave. It sits between the router's ring-forward path and the output link register.

## Interface
- `NUM_LOCAL`, default 2: number of local injection ports, minimum 1.
- `RING_WEIGHT`, default 4: maximum number of consecutive ring worms granted while any local port is requesting.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_ring` in `dii_flit`: through-ring flit (valid/last/data).
- `in_ring_ready` out 1: ring input accepted.
- `in_local` in `dii_flit [NUM_LOCAL]`: local injection flits.
- `in_local_ready` out `[NUM_LOCAL]`: per-port accept.
- `out_mux` out `dii_flit`: arbitrated output flit.
- `out_mux_ready` in 1: downstream accept.
- `grant_id` out `$clog2(NUM_LOCAL+1)`: current source; 0 is the ring, k is `in_local[k-1]`.
- `worm_active` out 1: a grant is locked.

## Operation
- **Transfer:** a transfer occurs on a source when `valid & ready` are both high in the same cycle.
- **States:**
  - IDLE: no locked grant.
  - WORM: grant locked to `grant_id`.
- **IDLE arbitration:** combinational, decided in the same cycle the request is seen.
  - **Ring preferred:** the ring wins if `in_ring.valid` and either `ring_cnt < RING_WEIGHT` or no local port is valid.
  - **Local winner:** otherwise the first valid local port at or after `rr_ptr` wins, searching cyclically.
- **Forwarding the winner:** `out_mux` = winner flit with valid=1, and the winner's ready = `out_mux_ready`. All other readys are 0.
- **Leaving IDLE:** the grant is registered and the block enters WORM unless the offered flit transfers with `last`=1.
  - A head flit that is offered but not accepted therefore locks the grant. `out_mux` stays stable until it transfers.
- **WORM:** `out_mux` mirrors the granted source, including its valid, and that source's ready = `out_mux_ready`.
  - WORM returns to IDLE on a transfer with `last`=1.
  - A granted source that deasserts valid mid-worm keeps the lock.
- **Counters:** updated on the worm-completing transfer, i.e. the transfer with `last`=1.
  - Ring worm completes: `ring_cnt` increments, saturating at `RING_WEIGHT`.
  - Local worm k completes: `ring_cnt` clears to 0 and `rr_ptr` becomes (k+1) mod `NUM_LOCAL`.
  - In an IDLE cycle with no local port valid, `ring_cnt` clears to 0.
- **Idle output:** when `out_mux.valid`=0, `data` and `last` are don't-care.
- **Reset:** asserting `rst_n` low at any time, including mid-worm, immediately forces:
  - IDLE, `ring_cnt`=0, `rr_ptr`=0, `grant_id`=0, `worm_active`=0;
  - `out_mux.valid`=0 and all readys 0.
  - Any truncated worm is the upstream's responsibility.

## Timing
- **Latency:** zero; valid, data and last pass combinationally from the granted input to `out_mux`.
- **Combinational path:** `out_mux_ready` reaches the granted input's ready combinationally.
- **Throughput:** one flit per cycle.
- **No bubble between worms:** the cycle after a last-flit transfer is IDLE and forwards the next winner in that same cycle.
- **Register update:** state, `grant_id`, `ring_cnt` and `rr_ptr` update on the rising `clk` edge.
  - `worm_active` and `grant_id` are registered outputs.
  - In IDLE, `grant_id` shows the last locked grant, not the combinational winner.
- **Simultaneous requests:** the ring and all local ports valid in the same IDLE cycle resolve per the IDLE arbitration rules above.
- **`RING_WEIGHT`=0:** a requesting local port always beats the ring.

## Structure
- **From `dii_package`:** `dii_flit`.
- **New in `dii_package`:**
  - localparam `RING_SRC_ID = 0`;
  - a function computing the `grant_id` width from `NUM_LOCAL`.
- **Sub-module `rr_arbiter`:** `N`-request one-hot round-robin grant from a request vector and pointer, purely combinational. It is instantiated once for the local ports.
- **Top level:** state register, counters and the output mux.

## Test plan
- **Ring-only single-flit worms:** `in_ring` valid, last=1, `out_mux_ready`=1 for 3 cycles → `out_mux` mirrors each flit the same cycle, `in_ring_ready`=1, `worm_active` stays 0.
- **Ring worm blocks local:** 3-flit ring worm with `in_local[0]` valid throughout → all 3 ring flits out consecutively, `in_local_ready[0]`=0 until the ring last flit transfers; local head appears the next cycle with no bubble.
- **Starvation bound:** `RING_WEIGHT`=2, ring and `in_local[1]` continuously valid with single-flit worms → output order ring, ring, local1, ring, ring, local1.
- **Local round-robin:** `NUM_LOCAL`=3, locals 0 and 2 always valid, ring idle → grants alternate 1, 3, 1, 3 (`grant_id`).
- **Backpressure on head:** `out_mux_ready`=0 with local0 head offered, then ring becomes valid → `out_mux` stays on local0 (`worm_active`=1, `grant_id`=1) until ready rises and the worm completes.
- **Reset mid-worm:** assert `rst_n` low during flit 2 of a 4-flit worm → `out_mux.valid`=0, `worm_active`=0 and readys 0 immediately, without waiting for a clock edge; after release, a new head is arbitrated from IDLE.
